// File: rtl/dec_uart_reporter.sv
// Snapshots four ASCII decimal digits on a trigger and sends them over UART 8N1
// as one text record ending in CR LF, optionally without leading zeros.
module dec_uart_reporter #(
  parameter int CLK_HZ         = 27000000,
  parameter int BAUD           = 115200,
  parameter int BIT_CYCLES     = CLK_HZ / BAUD,
  parameter bit SUPPRESS_ZEROS = 1'b1
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic [7:0] thousands,
  input  logic [7:0] hundreds,
  input  logic [7:0] tens,
  input  logic [7:0] units,
  input  logic       trigger,
  output logic       uart_tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [2:0] LAST_BYTE = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       byte_idx;
  logic [3:0][7:0]  digit_q;
  logic [7:0]       cur_byte;
  logic             cnt_last;

  // Record byte order: 0..3 are the digits, 4 is CR, 5 is LF.
  function automatic logic [2:0] start_index(input logic [7:0] th, input logic [7:0] hu,
                                             input logic [7:0] te);
    if (!SUPPRESS_ZEROS) return 3'd0;
    if (th != 8'h30)     return 3'd0;
    if (hu != 8'h30)     return 3'd1;
    if (te != 8'h30)     return 3'd2;
    return 3'd3;
  endfunction

  assign cnt_last = (cnt == CNT_LAST);

  // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx)
      3'd0, 3'd1, 3'd2, 3'd3: cur_byte = digit_q[byte_idx[1:0]];
      3'd4:                   cur_byte = 8'h0D;
      default:                cur_byte = 8'h0A;
    endcase
  end

  // uart_tx is registered, so each state drives the line from the edge after it is
  // entered; this gives the one-cycle trigger-to-start-bit latency.
  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // update together from the pre-edge values.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      // NOTE: the snapshot is only four bytes of flops, so it is reset along with
      // the control state rather than left as an unreset memory.
      digit_q  <= '0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          done    <= 1'b0;
          if (trigger) begin
            digit_q[0] <= thousands;
            digit_q[1] <= hundreds;
            digit_q[2] <= tens;
            digit_q[3] <= units;
            byte_idx   <= start_index(thousands, hundreds, tens);
            cnt        <= '0;
            bit_idx    <= '0;
            busy       <= 1'b1;
            state      <= START;
          end
        end

        START: begin
          uart_tx <= 1'b0;
          if (cnt_last) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          uart_tx <= cur_byte[bit_idx];
          if (cnt_last) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          uart_tx <= 1'b1;
          if (cnt_last) begin
            cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              state <= DONE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= START;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          uart_tx <= 1'b1;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          uart_tx <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_uart_reporter.sv
// Bench for dec_uart_reporter: one instance with leading-zero suppression, one without,
// each line checked cycle by cycle against a record built from the digit values.
module tb_dec_uart_reporter;

  localparam int BC = 10;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [7:0] th, hu, te, un;
  logic       trig_s, trig_n;
  logic       tx_s, busy_s, done_s;
  logic       tx_n, busy_n, done_n;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  dec_uart_reporter #(.CLK_HZ(1000), .BAUD(100), .SUPPRESS_ZEROS(1'b1)) dut (
    .clk(clk), .rst_ni(rst_ni), .thousands(th), .hundreds(hu), .tens(te), .units(un),
    .trigger(trig_s), .uart_tx(tx_s), .busy(busy_s), .done(done_s));

  dec_uart_reporter #(.CLK_HZ(1000), .BAUD(100), .SUPPRESS_ZEROS(1'b0)) dut_nz (
    .clk(clk), .rst_ni(rst_ni), .thousands(th), .hundreds(hu), .tens(te), .units(un),
    .trigger(trig_n), .uart_tx(tx_n), .busy(busy_n), .done(done_n));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input bit nz);
    return nz ? tx_n : tx_s;
  endfunction
  function automatic logic busy_of(input bit nz);
    return nz ? busy_n : busy_s;
  endfunction
  function automatic logic done_of(input bit nz);
    return nz ? done_n : done_s;
  endfunction

  task automatic set_trig(input bit nz, input logic v);
    if (nz) trig_n = v;
    else    trig_s = v;
  endtask

  // Expected record: digits from the first significant one (or all four), then CR LF.
  task automatic build_expected(input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3, input bit nz);
    logic [7:0] d[4];
    int first;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    first = 0;
    if (!nz) while (first < 3 && d[first] == 8'h30) first++;
    exp_q.delete();
    for (int i = first; i < 4; i++) exp_q.push_back(d[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Line level k cycles after the first start-bit edge: 10 bit slots per byte.
  function automatic logic model_bit(input int k);
    int idx, pos;
    logic [7:0] b;
    idx = k / (10 * BC);
    pos = (k / BC) % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    b = exp_q[idx];
    return b[pos-1];
  endfunction

  task automatic launch(input bit nz, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
    @(negedge clk);
    th = d0; hu = d1; te = d2; un = d3;
    build_expected(d0, d1, d2, d3, nz);
    set_trig(nz, 1'b1);
  endtask

  task automatic idle_check(input string tag, input bit nz);
    @(negedge clk);
    check({tag, ".idle_done"}, done_of(nz), 1'b0);
    check({tag, ".idle_busy"}, busy_of(nz), 1'b0);
    check({tag, ".idle_tx"},   tx_of(nz),   1'b1);
  endtask

  // Entered with the trigger already driven high before the accepting edge.
  task automatic run_record(input string tag, input bit nz, input int inject_k,
                            input int reset_k, input bit chain,
                            input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
    int span, wave_err, ctl_err, first_bad;
    span      = 10 * exp_q.size() * BC;
    wave_err  = 0;
    ctl_err   = 0;
    first_bad = -1;
    @(negedge clk);
    set_trig(nz, 1'b0);
    check({tag, ".busy_accept"}, busy_of(nz), 1'b1);
    check({tag, ".tx_latency"},  tx_of(nz),   1'b1);
    for (int k = 0; k < span; k++) begin
      @(negedge clk);
      if (tx_of(nz) !== model_bit(k)) begin
        wave_err++;
        if (first_bad < 0) first_bad = k;
      end
      if (busy_of(nz) !== 1'b1 || done_of(nz) !== 1'b0) ctl_err++;
      if (k == inject_k) begin
        set_trig(nz, 1'b1);
        th = 8'h39; hu = 8'h39; te = 8'h39; un = 8'h39;
      end
      if (k == inject_k + 1) set_trig(nz, 1'b0);
      if (k == reset_k) begin
        rst_ni = 1'b0;
        #1;
        check({tag, ".rst_tx"},   tx_of(nz),   1'b1);
        check({tag, ".rst_busy"}, busy_of(nz), 1'b0);
        check({tag, ".rst_done"}, done_of(nz), 1'b0);
        check({tag, ".pre_rst_wave_errs"}, wave_err, 0);
        return;
      end
    end
    check({tag, ".wave_errs"}, wave_err, 0);
    if (wave_err != 0) check({tag, ".first_bad_cycle"}, first_bad, -1);
    check({tag, ".ctl_errs"}, ctl_err, 0);
    @(negedge clk);
    check({tag, ".done_pulse"}, done_of(nz), 1'b1);
    check({tag, ".busy_fall"},  busy_of(nz), 1'b0);
    check({tag, ".done_tx"},    tx_of(nz),   1'b1);
    if (chain) begin
      th = c0; hu = c1; te = c2; un = c3;
      build_expected(c0, c1, c2, c3, nz);
      set_trig(nz, 1'b1);
    end
  endtask

  function automatic logic [7:0] rand_digit();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 4)  return 8'h30;
    if (r == 9) return 8'($urandom);
    return 8'h30 + 8'($urandom_range(0, 9));
  endfunction

  initial begin
    rst_ni = 1'b0;
    trig_s = 1'b0;
    trig_n = 1'b0;
    th = 8'h30; hu = 8'h30; te = 8'h30; un = 8'h30;
    repeat (2) @(negedge clk);
    check("reset.tx",      tx_s,   1'b1);
    check("reset.busy",    busy_s, 1'b0);
    check("reset.done",    done_s, 1'b0);
    check("reset.nz_tx",   tx_n,   1'b1);
    check("reset.nz_busy", busy_n, 1'b0);
    rst_ni = 1'b1;
    idle_check("post_reset", 1'b0);

    launch(1'b0, "0", "4", "0", "7");
    run_record("s0407", 1'b0, -10, -1, 1'b0, 0, 0, 0, 0);
    idle_check("s0407", 1'b0);

    launch(1'b0, "0", "0", "0", "0");
    run_record("s0000", 1'b0, -10, -1, 1'b0, 0, 0, 0, 0);
    idle_check("s0000", 1'b0);

    launch(1'b0, "4", "0", "9", "5");
    run_record("s4095", 1'b0, -10, -1, 1'b0, 0, 0, 0, 0);
    idle_check("s4095", 1'b0);

    launch(1'b1, "0", "0", "1", "2");
    run_record("n0012", 1'b1, -10, -1, 1'b0, 0, 0, 0, 0);
    idle_check("n0012", 1'b1);

    // Trigger and new digits mid-record must neither alter nor queue a record.
    launch(1'b0, "1", "2", "3", "4");
    run_record("ignore", 1'b0, 50, -1, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle_check("ignore_after", 1'b0);

    launch(1'b0, "0", "8", "3", "1");
    run_record("abort", 1'b0, -10, 137, 1'b0, 0, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort.held_done", done_s, 1'b0);
      check("abort.held_tx",   tx_s,   1'b1);
    end
    rst_ni = 1'b1;
    idle_check("abort_release", 1'b0);
    launch(1'b0, "0", "5", "6", "0");
    run_record("after_abort", 1'b0, -10, -1, 1'b0, 0, 0, 0, 0);
    idle_check("after_abort", 1'b0);

    launch(1'b0, "0", "0", "0", "9");
    run_record("chain_a", 1'b0, -10, -1, 1'b1, "7", "0", "0", "3");
    run_record("chain_b", 1'b0, -10, -1, 1'b0, 0, 0, 0, 0);
    idle_check("chain_b", 1'b0);

    for (int n = 0; n < 6; n++) begin
      bit nz;
      nz = 1'($urandom_range(0, 1));
      launch(nz, rand_digit(), rand_digit(), rand_digit(), rand_digit());
      run_record($sformatf("rand%0d", n), nz, -10, -1, 1'b0, 0, 0, 0, 0);
      idle_check($sformatf("rand%0d", n), nz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
